// File: rtl/hdmi_ctrl_pkg.sv
// Shared state encoding, default timing and width helpers for the HDMI source switch controller.
package hdmi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_MUTE      = 3'd1,
    ST_PLL_RST   = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_FIFO_RST  = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES      = 2;
  localparam int unsigned DEF_DEB_CYC          = 16;
  localparam int unsigned DEF_MUTE_CYC         = 1024;
  localparam int unsigned DEF_PLL_RST_CYC      = 64;
  localparam int unsigned DEF_LOCK_STABLE_CYC  = 256;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int unsigned DEF_FIFO_RST_CYC     = 16;
  localparam int unsigned DEF_SETTLE_CYC       = 512;
  localparam int unsigned DEF_MAX_RETRY        = 3;

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned STATE_W = 3;

  // Bits needed to hold values 0..n-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((64'd1 << w) < 64'(n))) w++;
    return w;
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchronizer followed by an optional consecutive-sample debouncer.
module sync_debounce
  import hdmi_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 2,
  parameter int unsigned DEB    = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  if (STAGES > 1) begin : g_chain
    // Synchronizer shift chain, newest sample in bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[STAGES-2:0], din};
    end
  end else begin : g_single
    // Single-flop synchronizer.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= din;
    end
  end

  if (DEB <= 1) begin : g_plain
    assign dout = sync_q[STAGES-1];
  end else begin : g_deb
    localparam int unsigned CW = clog2(DEB);
    logic [CW-1:0] cnt_q;
    logic          db_q;

    // Accept the synced value only after DEB consecutive cycles that differ from the current output.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else if (sync_q[STAGES-1] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB - 1)) begin
        cnt_q <= '0;
        db_q  <= sync_q[STAGES-1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign dout = db_q;
  end

endmodule

// File: rtl/hdmi_src_switch_ctrl.sv
// Sequences PLL reset, lock qualification, FIFO reset and blank/mute around HDMI source changes.
module hdmi_src_switch_ctrl
  import hdmi_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int unsigned DEB_CYC          = DEF_DEB_CYC,
  parameter int unsigned MUTE_CYC         = DEF_MUTE_CYC,
  parameter int unsigned PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned FIFO_RST_CYC     = DEF_FIFO_RST_CYC,
  parameter int unsigned SETTLE_CYC       = DEF_SETTLE_CYC,
  parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sel_req,
  input  logic               pll_locked,
  output logic               sel_out,
  output logic               pll_rst,
  output logic               fifo_rst,
  output logic               blank,
  output logic               audio_mute,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned TMR_MAX = umax(umax(umax(MUTE_CYC, PLL_RST_CYC),
                                              umax(LOCK_TIMEOUT_CYC, FIFO_RST_CYC)), SETTLE_CYC);
  localparam int unsigned TMR_W   = clog2(TMR_MAX);
  localparam int unsigned STB_W   = clog2(LOCK_STABLE_CYC);

  logic               sel_db;
  logic               lk_s;
  state_e             state;
  state_e             state_next;
  logic               go;
  logic               sel_chg;
  logic               boot;
  logic [TMR_W-1:0]   tmr;
  logic [STB_W-1:0]   stable;
  logic [RETRY_W-1:0] retry_next;
  logic [RETRY_W-1:0] retry_inc;
  logic               sel_nx;
  logic               pll_rst_nx;
  logic               fifo_rst_nx;
  logic               blank_nx;
  logic               ready_nx;
  logic               fault_nx;

  sync_debounce #(.STAGES(SYNC_STAGES), .DEB(DEB_CYC)) u_sel_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sel_req),
    .dout    (sel_db)
  );

  sync_debounce #(.STAGES(SYNC_STAGES), .DEB(1)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (pll_locked),
    .dout    (lk_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_PLL_RST;
    else          state <= state_next;
  end

  // Next state, retry bookkeeping and next-cycle output decode.
  always_comb begin
    state_next  = state;
    go          = 1'b0;
    retry_next  = retry_cnt;
    sel_chg     = (sel_db != sel_out);
    retry_inc   = (retry_cnt == RETRY_W'(15)) ? retry_cnt : retry_cnt + RETRY_W'(1);
    sel_nx      = sel_out;
    pll_rst_nx  = 1'b0;
    fifo_rst_nx = 1'b0;
    blank_nx    = 1'b1;
    ready_nx    = 1'b0;
    fault_nx    = 1'b0;

    case (state)
      ST_RUN: begin
        if (sel_chg || !lk_s) begin state_next = ST_MUTE; go = 1'b1; end
      end
      ST_MUTE: begin
        if (tmr == TMR_W'(MUTE_CYC - 1)) begin state_next = ST_PLL_RST; go = 1'b1; end
      end
      ST_PLL_RST: begin
        if (sel_chg) begin
          state_next = ST_PLL_RST; go = 1'b1; retry_next = '0;
        end else if (tmr == TMR_W'(PLL_RST_CYC - 1)) begin
          state_next = ST_WAIT_LOCK; go = 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (sel_chg) begin
          state_next = ST_PLL_RST; go = 1'b1; retry_next = '0;
        end else if (lk_s && (stable == STB_W'(LOCK_STABLE_CYC - 1))) begin
          state_next = ST_FIFO_RST; go = 1'b1;
        end else if (tmr == TMR_W'(LOCK_TIMEOUT_CYC - 1)) begin
          retry_next = retry_inc;
          go         = 1'b1;
          state_next = (retry_inc == RETRY_W'(MAX_RETRY)) ? ST_FAULT : ST_PLL_RST;
        end
      end
      ST_FIFO_RST: begin
        if (sel_chg) begin
          state_next = ST_PLL_RST; go = 1'b1; retry_next = '0;
        end else if (tmr == TMR_W'(FIFO_RST_CYC - 1)) begin
          state_next = ST_SETTLE; go = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (sel_chg) begin
          state_next = ST_PLL_RST; go = 1'b1; retry_next = '0;
        end else if (!lk_s) begin
          state_next = ST_MUTE; go = 1'b1;
        end else if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
          state_next = ST_RUN; go = 1'b1; retry_next = '0;
        end
      end
      ST_FAULT: begin
        if (sel_chg) begin state_next = ST_MUTE; go = 1'b1; retry_next = '0; end
      end
      default: begin
        state_next = ST_PLL_RST; go = 1'b1;
      end
    endcase

    // Source select only moves when the PLL is (re)entered into reset.
    if (boot || (go && (state_next == ST_PLL_RST))) sel_nx = sel_db;

    case (state_next)
      ST_RUN:       begin blank_nx = 1'b0; ready_nx = 1'b1; end
      ST_PLL_RST:   begin pll_rst_nx = 1'b1; fifo_rst_nx = 1'b1; end
      ST_WAIT_LOCK: fifo_rst_nx = 1'b1;
      ST_FIFO_RST:  fifo_rst_nx = 1'b1;
      ST_FAULT:     fault_nx = 1'b1;
      default:      ;
    endcase
  end

  // Registered outputs plus shared hold timer and lock-stability counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_out    <= 1'b0;
      pll_rst    <= 1'b1;
      fifo_rst   <= 1'b1;
      blank      <= 1'b1;
      audio_mute <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= '0;
      tmr        <= '0;
      stable     <= '0;
      boot       <= 1'b1;
    end else begin
      sel_out    <= sel_nx;
      pll_rst    <= pll_rst_nx;
      fifo_rst   <= fifo_rst_nx;
      blank      <= blank_nx;
      audio_mute <= blank_nx;
      ready      <= ready_nx;
      fault      <= fault_nx;
      retry_cnt  <= retry_next;
      tmr        <= go ? '0 : tmr + TMR_W'(1);
      stable     <= (go || !lk_s) ? '0 : stable + STB_W'(1);
      boot       <= 1'b0;
    end
  end

  assign state_o = state;

endmodule
